// File: rtl/if_pkg.sv
// -----------------------------------------------------------------------------
// if_pkg
// Shared definitions for the instruction-fetch stage:
//   - fetch_state_e    : fetch FSM states (IDLE / REQ / WAIT)
//   - NOP_INST         : canonical nop (addi x0,x0,0) used for fault entries
//   - RESET_PC_DEFAULT : default fetch PC after reset
//   - fetch_entry_t    : one buffered {pc, instruction} pair
//   - next_word_pc()   : sequential fetch PC, wraps modulo 2^32
// -----------------------------------------------------------------------------
package if_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_INST         = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    // 0xFFFF_FFFC rolls over to 0x0000_0000 through natural 32-bit overflow.
    function automatic logic [31:0] next_word_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/if_fetch_buf.sv
// -----------------------------------------------------------------------------
// if_fetch_buf
// Small FIFO of fetch_entry_t between instruction memory and decode.
// Parameters:
//   BUF_DEPTH   : number of entries (power of two, >= 2)
// Ports:
//   clk         : core clock
//   rst_n       : asynchronous active-low reset
//   i_push      : write i_push_data at the tail
//   i_push_data : entry to write
//   i_pop       : retire the head entry
//   i_flush     : discard all entries; overrides push and pop
//   o_head      : head entry (meaningful only when o_empty = 0)
//   o_count     : number of valid entries (0 .. BUF_DEPTH)
//   o_empty     : no valid entries
// A push and pop in the same cycle on a full buffer is accepted and leaves
// the count unchanged. Pointers wrap naturally because the depth is a power
// of two.
// -----------------------------------------------------------------------------
module if_fetch_buf
    import if_pkg::*;
#(
    parameter  int BUF_DEPTH = 2,
    localparam int PTR_W     = $clog2(BUF_DEPTH),
    localparam int CNT_W     = $clog2(BUF_DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_push,
    input  fetch_entry_t       i_push_data,
    input  logic               i_pop,
    input  logic               i_flush,
    output fetch_entry_t       o_head,
    output logic [CNT_W-1:0]   o_count,
    output logic               o_empty
);

    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(BUF_DEPTH);

    fetch_entry_t       r_mem [BUF_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    logic               w_full;
    logic               w_empty;
    logic               w_do_push;
    logic               w_do_pop;

    assign w_full    = (r_count == DEPTH_CNT);
    assign w_empty   = (r_count == {CNT_W{1'b0}});
    // A full buffer may still accept a push when the head leaves the same cycle.
    assign w_do_push = i_push && !i_flush && (!w_full || i_pop);
    assign w_do_pop  = i_pop  && !i_flush && !w_empty;

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_empty = w_empty;

    // Entry storage: only the slot under the write pointer changes on a push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointer and occupancy bookkeeping; flush returns to the empty state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
        end else if (i_flush) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/if_fetch.sv
// -----------------------------------------------------------------------------
// if_fetch
// Instruction-fetch stage. Owns the fetch PC, issues one word request at a
// time to instruction memory over req/gnt/rvalid, buffers {pc, instruction}
// pairs and presents them to decode over valid/ready.
// Parameters:
//   RESET_PC       : fetch PC after reset
//   BUF_DEPTH      : instruction buffer entries (power of two, >= 2)
// Ports:
//   clk, rst_n     : core clock, asynchronous active-low reset
//   redirect_valid : load redirect_pc, flush buffer and in-flight fetch
//   redirect_pc    : redirect target from the next-PC block
//   fetch_pc       : current fetch PC (to the next-PC block)
//   imem_req/addr  : memory request and word address
//   imem_gnt       : request accepted this cycle
//   imem_rvalid    : response valid (one per grant, at least a cycle later)
//   imem_rdata     : instruction word
//   inst_valid/ready, inst_pc, inst_data : decode interface (buffer head)
//   inst_fault     : only with IF_FETCH_MISALIGN_CHK_EN; head is a
//                    misaligned-redirect fault entry
// Build option:
//   IF_FETCH_MISALIGN_CHK_EN : a redirect with redirect_pc[1:0] != 0 raises a
//   sticky fault instead of silently aligning the target.
// -----------------------------------------------------------------------------
module if_fetch
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] fetch_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_pc,
`ifdef IF_FETCH_MISALIGN_CHK_EN
    output logic [31:0] inst_data,
    output logic        inst_fault
`else
    output logic [31:0] inst_data
`endif
);

    localparam int               CNT_W     = $clog2(BUF_DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(BUF_DEPTH);

    fetch_state_e       r_state;
    fetch_state_e       w_state_raw;
    fetch_state_e       w_state_nxt;
    logic [31:0]        r_fetch_pc;
    logic [31:0]        w_fetch_pc_nxt;
    logic [31:0]        r_issued_pc;
    logic [31:0]        w_issued_pc_nxt;
    logic               r_drop;
    logic               w_drop_nxt;

    logic               w_push;
    logic               w_pop;
    logic               w_flush;
    fetch_entry_t       w_push_entry;
    fetch_entry_t       w_head;
    logic [CNT_W-1:0]   w_count;
    logic               w_empty;
    logic [CNT_W-1:0]   w_count_after;
    logic               w_room_now;
    logic               w_room_after;
    logic [31:0]        w_redirect_aligned;

    logic               w_halt;
    logic               w_fault_nxt;

`ifdef IF_FETCH_MISALIGN_CHK_EN
    logic               r_fault;
    logic [31:0]        r_fault_pc;
    logic               w_fault_set;

    assign w_fault_set = redirect_valid && (redirect_pc[1:0] != 2'b00);
    // Fault is sticky: only the next redirect can set or clear it.
    assign w_fault_nxt = redirect_valid ? w_fault_set : r_fault;
    assign w_halt      = r_fault;
    assign inst_fault  = r_fault;

    // Sticky misaligned-redirect fault and the offending target.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fault    <= 1'b0;
            r_fault_pc <= 32'h0000_0000;
        end else begin
            r_fault <= w_fault_nxt;
            if (w_fault_set) begin
                r_fault_pc <= redirect_pc;
            end
        end
    end
`else
    logic               w_unused_redirect_lsb;

    // Low target bits are discarded when the misalignment check is absent.
    assign w_unused_redirect_lsb = ^redirect_pc[1:0];
    assign w_fault_nxt           = 1'b0;
    assign w_halt                = 1'b0;
`endif

    assign w_redirect_aligned = {redirect_pc[31:2], 2'b00};

    assign fetch_pc  = r_fetch_pc;
    assign imem_addr = r_fetch_pc;
    assign imem_req  = (r_state == REQ);

    // A redirect flushes the buffer and suppresses any same-cycle push/pop.
    assign w_flush      = redirect_valid;
    assign w_push       = (r_state == WAIT) && imem_rvalid && !r_drop
                          && !redirect_valid && !w_halt;
    assign w_pop        = !w_empty && inst_ready && !redirect_valid && !w_halt;
    assign w_push_entry = '{pc: r_issued_pc, inst: imem_rdata};

    // Occupancy once this cycle's push/pop land; a new request is only
    // issued when its response is guaranteed a slot.
    assign w_count_after = w_count + CNT_W'(w_push) - CNT_W'(w_pop);
    assign w_room_now    = (w_count < DEPTH_CNT);
    assign w_room_after  = (w_count_after < DEPTH_CNT);

    if_fetch_buf #(
        .BUF_DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_push_data (w_push_entry),
        .i_pop       (w_pop),
        .i_flush     (w_flush),
        .o_head      (w_head),
        .o_count     (w_count),
        .o_empty     (w_empty)
    );

    // Fetch FSM next-state; redirect handling overrides the normal flow.
    always_comb begin
        w_state_raw     = r_state;
        w_fetch_pc_nxt  = r_fetch_pc;
        w_issued_pc_nxt = r_issued_pc;
        w_drop_nxt      = r_drop;

        case (r_state)
            IDLE: begin
                if (w_room_now) begin
                    w_state_raw = REQ;
                end else begin
                    w_state_raw = IDLE;
                end
            end
            REQ: begin
                if (imem_gnt) begin
                    w_issued_pc_nxt = r_fetch_pc;
                    w_fetch_pc_nxt  = next_word_pc(r_fetch_pc);
                    w_state_raw     = WAIT;
                end else begin
                    w_state_raw = REQ;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    w_drop_nxt = 1'b0;
                    if (w_room_after) begin
                        w_state_raw = REQ;
                    end else begin
                        w_state_raw = IDLE;
                    end
                end else begin
                    w_state_raw = WAIT;
                end
            end
            default: begin
                w_state_raw = IDLE;
            end
        endcase

        if (redirect_valid) begin
            w_fetch_pc_nxt = w_redirect_aligned;
            case (r_state)
                WAIT: begin
                    if (imem_rvalid) begin
                        // Response arrives with the redirect: discard it here.
                        w_drop_nxt  = 1'b0;
                        w_state_raw = REQ;
                    end else begin
                        // Response still outstanding: discard it when it comes.
                        w_drop_nxt  = 1'b1;
                        w_state_raw = WAIT;
                    end
                end
                REQ: begin
                    if (imem_gnt) begin
                        // Grant already given; its response must be thrown away.
                        w_drop_nxt  = 1'b1;
                        w_state_raw = WAIT;
                    end else begin
                        w_state_raw = REQ;
                    end
                end
                default: begin
                    w_state_raw = REQ;
                end
            endcase
        end else begin
            w_fetch_pc_nxt = w_fetch_pc_nxt;
        end
    end

    // A faulted stage never issues new requests; outstanding ones still drain.
    assign w_state_nxt = (w_fault_nxt && (w_state_raw == REQ)) ? IDLE : w_state_raw;

    // Fetch state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_fetch_pc  <= {RESET_PC[31:2], 2'b00};
            r_issued_pc <= 32'h0000_0000;
            r_drop      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_fetch_pc  <= w_fetch_pc_nxt;
            r_issued_pc <= w_issued_pc_nxt;
            r_drop      <= w_drop_nxt;
        end
    end

    // Decode interface: head entry, or the fault entry while faulted.
    always_comb begin
        inst_valid = 1'b0;
        inst_pc    = 32'h0000_0000;
        inst_data  = 32'h0000_0000;
`ifdef IF_FETCH_MISALIGN_CHK_EN
        if (r_fault) begin
            inst_valid = 1'b1;
            inst_pc    = r_fault_pc;
            inst_data  = NOP_INST;
        end else if (!w_empty) begin
            inst_valid = 1'b1;
            inst_pc    = w_head.pc;
            inst_data  = w_head.inst;
        end else begin
            inst_valid = 1'b0;
        end
`else
        if (!w_empty) begin
            inst_valid = 1'b1;
            inst_pc    = w_head.pc;
            inst_data  = w_head.inst;
        end else begin
            inst_valid = 1'b0;
        end
`endif
    end

endmodule

// File: tb/tb_if_fetch.sv
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] fetch_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_pc;
    logic [31:0] inst_data;
`ifdef IF_FETCH_MISALIGN_CHK_EN
    logic        inst_fault;
`endif

    int          n_checks = 0;
    int          n_fail   = 0;
    logic        g_fire;
    logic [31:0] g_fire_addr;
    int          n_grants;

    always #5 clk = ~clk;

    if_fetch #(
        .RESET_PC  (32'h0000_0000),
        .BUF_DEPTH (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch_pc       (fetch_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_pc        (inst_pc),
`ifdef IF_FETCH_MISALIGN_CHK_EN
        .inst_data      (inst_data),
        .inst_fault     (inst_fault)
`else
        .inst_data      (inst_data)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = 32'h0;
        inst_ready     = 1'b0;
        n_grants       = 0;
        g_fire         = 1'b0;
        g_fire_addr    = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
    endtask

    // Memory responder: answers a grant one cycle later with C0DE_0000 + addr.
    task automatic step_auto();
        logic        fire;
        logic [31:0] a;
        fire = imem_req && imem_gnt;
        a    = imem_addr;
        tick();
        g_fire      = fire;
        g_fire_addr = a;
        if (fire) n_grants++;
        imem_rvalid = fire;
        imem_rdata  = fire ? (32'hC0DE_0000 + a) : 32'h0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0; inst_ready = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (fetch_pc !== 32'h0) begin n_fail++; $display("FAIL reset_fetch_pc: got %h expected %h", fetch_pc, 32'h0); end
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_imem_req: got %b expected 0", imem_req); end
        n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL reset_inst_valid: got %b expected 0", inst_valid); end
        n_checks++; if (inst_pc !== 32'h0) begin n_fail++; $display("FAIL reset_inst_pc: got %h expected %h", inst_pc, 32'h0); end
        n_checks++; if (inst_data !== 32'h0) begin n_fail++; $display("FAIL reset_inst_data: got %h expected %h", inst_data, 32'h0); end
        rst_n = 1'b1;
        tick();
        n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL reset_first_req: got %b expected 1", imem_req); end
        n_checks++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_first_addr: got %h expected %h", imem_addr, 32'h0); end
    endtask

    task automatic test_fetch_seq();
        logic [31:0] exp_pc [0:2];
        logic [31:0] exp_dat [0:2];
        int ng;
        int ni;
        exp_pc[0] = 32'h0000_0000; exp_dat[0] = 32'hC0DE_0000;
        exp_pc[1] = 32'h0000_0004; exp_dat[1] = 32'hC0DE_0004;
        exp_pc[2] = 32'h0000_0008; exp_dat[2] = 32'hC0DE_0008;
        ng = 0; ni = 0;
        apply_reset();
        imem_gnt = 1'b1; inst_ready = 1'b1;
        for (int c = 0; c < 40 && ni < 3; c++) begin
            step_auto();
            if (g_fire && ng < 3) begin
                n_checks++; if (g_fire_addr !== exp_pc[ng]) begin n_fail++; $display("FAIL seq_req_addr%0d: got %h expected %h", ng, g_fire_addr, exp_pc[ng]); end
                ng++;
            end
            if (inst_valid && ni < 3) begin
                n_checks++; if (inst_pc !== exp_pc[ni]) begin n_fail++; $display("FAIL seq_inst_pc%0d: got %h expected %h", ni, inst_pc, exp_pc[ni]); end
                n_checks++; if (inst_data !== exp_dat[ni]) begin n_fail++; $display("FAIL seq_inst_data%0d: got %h expected %h", ni, inst_data, exp_dat[ni]); end
                n_checks++; if (c !== 2 + 2 * ni) begin n_fail++; $display("FAIL seq_latency%0d: got cycle %0d expected %0d", ni, c, 2 + 2 * ni); end
                ni++;
            end
        end
        n_checks++; if (ni !== 3) begin n_fail++; $display("FAIL seq_timeout: got %0d instructions expected 3", ni); end
    endtask

    task automatic test_backpressure();
        logic [31:0] last_addr;
        apply_reset();
        imem_gnt = 1'b1; inst_ready = 1'b0;
        repeat (10) step_auto();
        n_checks++; if (n_grants !== 2) begin n_fail++; $display("FAIL bp_grants_full: got %0d expected 2", n_grants); end
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL bp_req_idle: got %b expected 0", imem_req); end
        n_checks++; if (inst_pc !== 32'h0) begin n_fail++; $display("FAIL bp_head_pc: got %h expected %h", inst_pc, 32'h0); end
        n_checks++; if (inst_data !== 32'hC0DE_0000) begin n_fail++; $display("FAIL bp_head_data: got %h expected %h", inst_data, 32'hC0DE_0000); end
        n_grants = 0; last_addr = 32'hFFFF_FFFF;
        inst_ready = 1'b1;
        step_auto();
        inst_ready = 1'b0;
        n_checks++; if (inst_pc !== 32'h4) begin n_fail++; $display("FAIL bp_head_after_pop: got %h expected %h", inst_pc, 32'h4); end
        for (int c = 0; c < 10; c++) begin
            step_auto();
            if (g_fire) last_addr = g_fire_addr;
        end
        n_checks++; if (n_grants !== 1) begin n_fail++; $display("FAIL bp_one_new_req: got %0d expected 1", n_grants); end
        n_checks++; if (last_addr !== 32'h8) begin n_fail++; $display("FAIL bp_new_req_addr: got %h expected %h", last_addr, 32'h8); end
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL bp_req_idle2: got %b expected 0", imem_req); end
    endtask

    task automatic test_redirect_wait();
        apply_reset();
        inst_ready = 1'b1;
        tick();
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
        tick();
        redirect_valid = 1'b0;
        n_checks++; if (fetch_pc !== 32'h100) begin n_fail++; $display("FAIL rw_fetch_pc: got %h expected %h", fetch_pc, 32'h100); end
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rw_still_wait: got %b expected 0", imem_req); end
        imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_rvalid = 1'b0;
        n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL rw_dropped: got %b expected 0", inst_valid); end
        n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL rw_req: got %b expected 1", imem_req); end
        n_checks++; if (imem_addr !== 32'h100) begin n_fail++; $display("FAIL rw_addr: got %h expected %h", imem_addr, 32'h100); end
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h1111_0100;
        tick();
        imem_rvalid = 1'b0;
        n_checks++; if (inst_valid !== 1'b1) begin n_fail++; $display("FAIL rw_valid: got %b expected 1", inst_valid); end
        n_checks++; if (inst_pc !== 32'h100) begin n_fail++; $display("FAIL rw_inst_pc: got %h expected %h", inst_pc, 32'h100); end
        n_checks++; if (inst_data !== 32'h1111_0100) begin n_fail++; $display("FAIL rw_inst_data: got %h expected %h", inst_data, 32'h1111_0100); end
    endtask

    task automatic test_redirect_req_gnt();
        apply_reset();
        tick();
        imem_gnt = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0500;
        tick();
        imem_gnt = 1'b0; redirect_valid = 1'b0;
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rq_wait: got %b expected 0", imem_req); end
        n_checks++; if (fetch_pc !== 32'h500) begin n_fail++; $display("FAIL rq_fetch_pc: got %h expected %h", fetch_pc, 32'h500); end
        imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0000;
        tick();
        imem_rvalid = 1'b0;
        n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL rq_dropped: got %b expected 0", inst_valid); end
        n_checks++; if (imem_addr !== 32'h500) begin n_fail++; $display("FAIL rq_addr: got %h expected %h", imem_addr, 32'h500); end
    endtask

    task automatic test_redirect_flush();
        int found;
        apply_reset();
        imem_gnt = 1'b1; inst_ready = 1'b0;
        repeat (4) step_auto();
        n_checks++; if (inst_pc !== 32'h0 || imem_rvalid !== 1'b1) begin n_fail++; $display("FAIL rf_setup: got pc %h rvalid %b expected pc 0 rvalid 1", inst_pc, imem_rvalid); end
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0300; inst_ready = 1'b1;
        tick();
        redirect_valid = 1'b0; imem_rvalid = 1'b0;
        n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL rf_empty: got %b expected 0", inst_valid); end
        n_checks++; if (imem_addr !== 32'h300 || imem_req !== 1'b1) begin n_fail++; $display("FAIL rf_addr: got %h req %b expected 300 req 1", imem_addr, imem_req); end
        found = 0;
        for (int c = 0; c < 10 && found == 0; c++) begin
            step_auto();
            if (inst_valid) begin
                found = 1;
                n_checks++; if (inst_pc !== 32'h300) begin n_fail++; $display("FAIL rf_first_pc: got %h expected %h", inst_pc, 32'h300); end
                n_checks++; if (inst_data !== 32'hC0DE_0300) begin n_fail++; $display("FAIL rf_first_data: got %h expected %h", inst_data, 32'hC0DE_0300); end
            end
        end
        n_checks++; if (found !== 1) begin n_fail++; $display("FAIL rf_timeout: got %0d expected 1", found); end
        // Full buffer, idle, redirect together with a pop.
        apply_reset();
        imem_gnt = 1'b1; inst_ready = 1'b0;
        repeat (10) step_auto();
        n_checks++; if (imem_req !== 1'b0 || inst_valid !== 1'b1) begin n_fail++; $display("FAIL rf_full_setup: got req %b valid %b expected 0 1", imem_req, inst_valid); end
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0400; inst_ready = 1'b1;
        tick();
        redirect_valid = 1'b0; inst_ready = 1'b0;
        n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL rf_full_empty: got %b expected 0", inst_valid); end
        n_checks++; if (imem_addr !== 32'h400 || imem_req !== 1'b1) begin n_fail++; $display("FAIL rf_full_addr: got %h req %b expected 400 req 1", imem_addr, imem_req); end
    endtask

    task automatic test_wrap();
        apply_reset();
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0; imem_gnt = 1'b1;
        n_checks++; if (imem_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_addr_hi: got %h expected %h", imem_addr, 32'hFFFF_FFFC); end
        tick();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000_7777;
        n_checks++; if (fetch_pc !== 32'h0) begin n_fail++; $display("FAIL wrap_fetch_pc: got %h expected %h", fetch_pc, 32'h0); end
        tick();
        imem_rvalid = 1'b0;
        n_checks++; if (imem_addr !== 32'h0 || imem_req !== 1'b1) begin n_fail++; $display("FAIL wrap_next_addr: got %h req %b expected 0 req 1", imem_addr, imem_req); end
        n_checks++; if (inst_pc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_inst_pc: got %h expected %h", inst_pc, 32'hFFFF_FFFC); end
    endtask

`ifndef IF_FETCH_MISALIGN_CHK_EN
    task automatic test_low_bits();
        apply_reset();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
        tick();
        redirect_valid = 1'b0;
        n_checks++; if (imem_addr !== 32'h100) begin n_fail++; $display("FAIL lowbits_addr: got %h expected %h", imem_addr, 32'h100); end
    endtask
`else
    task automatic test_misalign();
        apply_reset();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0102;
        tick();
        redirect_valid = 1'b0;
        n_checks++; if (inst_fault !== 1'b1) begin n_fail++; $display("FAIL mis_fault: got %b expected 1", inst_fault); end
        n_checks++; if (inst_valid !== 1'b1) begin n_fail++; $display("FAIL mis_valid: got %b expected 1", inst_valid); end
        n_checks++; if (inst_pc !== 32'h102) begin n_fail++; $display("FAIL mis_pc: got %h expected %h", inst_pc, 32'h102); end
        n_checks++; if (inst_data !== 32'h13) begin n_fail++; $display("FAIL mis_data: got %h expected %h", inst_data, 32'h13); end
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL mis_req: got %b expected 0", imem_req); end
        inst_ready = 1'b1; imem_gnt = 1'b1;
        repeat (4) tick();
        n_checks++; if (inst_fault !== 1'b1 || imem_req !== 1'b0) begin n_fail++; $display("FAIL mis_sticky: got fault %b req %b expected 1 0", inst_fault, imem_req); end
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0200; imem_gnt = 1'b0;
        tick();
        redirect_valid = 1'b0;
        n_checks++; if (inst_fault !== 1'b0 || inst_valid !== 1'b0) begin n_fail++; $display("FAIL mis_clear: got fault %b valid %b expected 0 0", inst_fault, inst_valid); end
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin n_fail++; $display("FAIL mis_resume: got req %b addr %h expected 1 200", imem_req, imem_addr); end
    endtask
`endif

    initial begin
        test_reset();
        test_fetch_seq();
        test_backpressure();
        test_redirect_wait();
        test_redirect_req_gnt();
        test_redirect_flush();
        test_wrap();
`ifndef IF_FETCH_MISALIGN_CHK_EN
        test_low_bits();
`else
        test_misalign();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage directly downstream of the next-PC logic. It owns the architectural fetch PC and issues word requests to instruction memory over a req/gnt/rvalid handshake.
- Fetched {pc, instruction} pairs are buffered in a small FIFO and handed to decode over a valid/ready interface.
- The next-PC block's output is consumed as the redirect target whenever a jal, taken branch or jalr resolves.

Parameters:
- RESET_PC, 32'h0000_0000, fetch PC loaded on reset.
- BUF_DEPTH, 2, instruction buffer entries (power of two, >=2).

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- redirect_valid  in  1  pulse: load redirect_pc and flush in-flight fetches.
- redirect_pc  in  32  target from next-PC block (next_pc).
- fetch_pc  out  32  current fetch PC (feeds next-PC block's pc input).
- imem_req  out  1  memory request valid.
- imem_addr  out  32  word address = fetch_pc, bits[1:0] always 0.
- imem_gnt  in  1  request accepted this cycle when imem_req=1.
- imem_rvalid  in  1  read data valid; exactly one per granted request, >=1 cycle after gnt.
- imem_rdata  in  32  instruction word.
- inst_valid  out  1  buffer head valid.
- inst_ready  in  1  decode accepts head.
- inst_pc  out  32  PC of head instruction.
- inst_data  out  32  head instruction.

Behaviour:
- Reset (async assert, sync-free release): fetch_pc=RESET_PC, state=IDLE, buffer empty, drop flag=0, imem_req=0, inst_valid=0, inst_pc=0, inst_data=0.
- FSM states: IDLE, REQ, WAIT.
- IDLE -> REQ when slots_free = BUF_DEPTH - count > 0.
- REQ: imem_req=1, imem_addr=fetch_pc. On gnt: latch issued_pc=fetch_pc, fetch_pc+=4 (mod 2^32, wraps 0xFFFF_FFFC->0), -> WAIT.
- WAIT: imem_req=0. On rvalid: push {issued_pc, rdata} unless drop=1. Then -> REQ if a slot remains after the push (including a same-cycle pop), else -> IDLE.
- At most one outstanding request. A request is issued only if the response is guaranteed a slot.
- Buffer: push on rvalid&&!drop, pop on inst_valid&&inst_ready. Simultaneous push+pop on a full buffer is legal and count is unchanged. Read and write pointers wrap modulo BUF_DEPTH.
- Pop-to-output latency 0: inst_* are driven combinationally from the head. Fetch-to-decode latency: data visible the cycle after rvalid.
- Redirect (highest priority, any state):
  - fetch_pc <= {redirect_pc[31:2],2'b00}; buffer cleared; same-cycle pop ignored.
  - In WAIT with no rvalid that cycle: drop<=1, stay in WAIT. The next rvalid is discarded, drop clears, then -> REQ.
  - In WAIT with rvalid in the same cycle: the response is discarded, no drop set, -> REQ.
  - In REQ with gnt in the same cycle: the grant stands, drop<=1, -> WAIT.
  - In REQ without gnt, or in IDLE: -> REQ.
- imem_addr must hold stable while imem_req=1 and gnt=0, except after a redirect, which may change it.
- inst_valid is never asserted for a flushed or dropped instruction.

Optional Feature:
- Macro: IF_FETCH_MISALIGN_CHK_EN.
- With the macro, port inst_fault (out, 1) is added.
  - redirect_pc[1:0]!=0 sets a sticky fault: buffer flushed, no further requests, inst_valid=1 with inst_pc=redirect_pc (unaligned), inst_data=32'h0000_0013 (nop), inst_fault=1.
  - The fault entry persists until the next redirect, which clears it. Popping the fault entry does not clear it.
- Without the macro, low bits are silently forced to 0 and no fault port exists.

Decomposition:
- Shared package if_pkg:
  - fetch-state enum (IDLE/REQ/WAIT);
  - NOP_INST=32'h0000_0013;
  - RESET_PC default;
  - typedef fetch_entry_t {pc[31:0], inst[31:0]}.
- One sub-module: if_fetch_buf (parameterised BUF_DEPTH FIFO of fetch_entry_t with push, pop, flush, count).

Test Plan:
- Reset, then gnt tied 1 and rvalid one cycle later, with inst_ready=1 -> addresses 0x0, 0x4, 0x8 issued; inst_pc follows 0x0, 0x4, 0x8 with matching rdata.
- inst_ready=0 -> after 2 instructions buffered, imem_req stays 0. inst_ready=1 for one cycle -> exactly one new request.
- Redirect to 0x100 while in WAIT -> next rvalid (data 0xDEAD_BEEF) is dropped; next request address is 0x100; first inst_pc=0x100.
- Redirect in the same cycle as rvalid and a pop on a full buffer -> buffer empty, count=0, next imem_addr=redirect target.
- fetch_pc=0xFFFF_FFFC granted -> next imem_addr=0x0000_0000.
- With IF_FETCH_MISALIGN_CHK_EN, redirect_pc=0x102 -> inst_fault=1, inst_pc=0x102, inst_data=0x13, no imem_req. A later redirect to 0x200 clears the fault and resumes fetching.
